cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL provide parameter IMG_W, 320, pixels stored per line.
REQ-002 SHALL provide parameter IMG_H, 240, lines stored per frame.
REQ-003 SHALL provide parameter ADDR_W, 17, frame-buffer address width, at least clog2(IMG_W*IMG_H).
REQ-004 SHALL have port clk_i  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  in  1  one-cycle capture request.
REQ-007 SHALL have port continuous_i  in  1  1 = capture every frame, 0 = single frame.
REQ-008 SHALL have port pclk_i  in  1  camera pixel clock, asynchronous, sampled as data only.
REQ-009 SHALL have port vsync_i  in  1  camera frame sync; high = vertical blanking.
REQ-010 SHALL have port href_i  in  1  camera line-valid.
REQ-011 SHALL have port data_i  in  8  camera bytes, RGB565, high byte first.
REQ-012 SHALL have port we_o  out  1  frame-buffer write strobe.
REQ-013 SHALL have port addr_o  out  ADDR_W  frame-buffer write address.
REQ-014 SHALL have port pixel_o  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-015 SHALL have port frame_done_o  out  1  one-cycle pulse at end of a captured frame.
REQ-016 SHALL have port busy_o  out  1  high in WAIT_VS or CAPTURE.

Function
REQ-017 SHALL pass pclk_i, href_i, vsync_i and data_i through one shared 2-flop synchronizer pipeline and detect edges on the stage-2 outputs.
REQ-018 SHALL sample the byte from data stage 2 on a synced pclk 0->1 edge.
REQ-019 SHALL implement FSM IDLE, WAIT_VS, CAPTURE.
REQ-020 SHALL go IDLE->WAIT_VS on start_i; start_i SHALL be ignored outside IDLE.
REQ-021 SHALL go WAIT_VS->CAPTURE on a synced vsync falling edge and clear x, y, line base and byte phase on entry.
REQ-022 SHALL, on a synced vsync rising edge in CAPTURE, pulse frame_done_o for one cycle, then go to WAIT_VS if continuous_i=1, else to IDLE.
REQ-023 SHALL, in CAPTURE with href high, toggle the byte phase on each pclk edge: phase 0 stores hi, phase 1 forms a pixel.
REQ-024 SHALL form pixel_o = {hi[7:4], hi[2:0], lo[7], lo[4:1]}.
REQ-025 SHALL assert we_o for exactly one cycle per pixel, with addr_o = line_base + x, both registered.
REQ-026 SHALL make we_o rise exactly 4 clk_i cycles after the pclk_i rise carrying lo: 2 sync stages, 1 edge stage, 1 output register.
REQ-027 SHALL increment x after each pixel, saturating at IMG_W.
REQ-028 SHALL suppress writes while x >= IMG_W or y >= IMG_H.
REQ-029 SHALL, on a synced href falling edge with x > 0, set x=0, y=y+1 (saturating at IMG_H) and line_base += IMG_W.
REQ-030 SHALL clear the byte phase on href low; a dangling odd byte SHALL be dropped.
REQ-031 SHALL, on start_i while vsync is already low, wait for the next falling edge, so no partial frame is ever written.
REQ-032 SHALL still pulse frame_done_o on a short frame (fewer than IMG_H lines).
REQ-033 SHALL sample continuous_i only at the frame-end decision.

Reset
REQ-034 SHALL, on rst_i, force state=IDLE and we_o, addr_o, pixel_o, frame_done_o, busy_o, counters and phase to 0.
REQ-035 SHALL reset all vsync synchronizer stages to 1, so no false falling edge appears after reset.
REQ-036 SHALL, on rst_i mid-frame, abort capture with no further writes until a new start_i followed by a full vsync falling edge.

Structure
REQ-037 SHALL take from package cam_pkg: cam_state_t enum, rgb444_t typedef, IMG_W/IMG_H defaults and function rgb565_to_444.
REQ-038 SHALL use sub-module sync_edge (2-flop synchronizer plus rise/fall pulses), instantiated for pclk, href and vsync.

Verification
REQ-039 SHALL cover: IMG_W=8, IMG_H=4, continuous_i=0, start_i, one frame of 4 lines x 8 pixels with hi=0xF8, lo=0x1F -> 32 writes, pixel_o=0xF0F, addr_o 0..31 in order, one frame_done_o, then busy_o=0 and IDLE.
REQ-040 SHALL cover: line of 10 pixels with IMG_W=8 -> pixels 8-9 not written; next line's first write has addr_o=8.
REQ-041 SHALL cover: start_i mid-frame with vsync low -> zero writes until vsync high->low; first write addr_o=0.
REQ-042 SHALL cover: continuous_i=1 over two frames -> two frame_done_o pulses; second frame restarts at addr_o=0.
REQ-043 SHALL cover: a 3-byte line -> exactly one write; next line's first pixel correctly byte-aligned.
REQ-044 SHALL cover: rst_i mid-line -> all outputs 0 the cycle after reset, no writes until a new start_i.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared types, frame-size defaults and pixel conversion for the
// camera capture block.
//   cam_state_t   - capture FSM states
//   rgb444_t      - 12-bit {R[3:0],G[3:0],B[3:0]} pixel
//   rgb565_to_444 - reduces an RGB565 byte pair (high byte first) to RGB444
package cam_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } cam_state_t;

    typedef logic [11:0] rgb444_t;

    // hi = RRRRRGGG, lo = GGGBBBBB; keep the top 4 bits of each channel.
    function automatic rgb444_t rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for one asynchronous input, plus registered
// single-cycle rise/fall pulses detected on the second synchronizer stage.
//   clk_i   - system clock
//   rst_i   - synchronous active-high reset; all stages load RST_VAL
//   d_i     - asynchronous input
//   level_o - synchronized level (stage 2)
//   rise_o  - one-cycle pulse after a 0->1 transition of stage 2
//   fall_o  - one-cycle pulse after a 1->0 transition of stage 2
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_reg, s2_reg, s3_reg;
    logic rise_reg, fall_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Loading the idle level everywhere keeps a spurious edge from
            // appearing when reset is released.
            s1_reg   <= RST_VAL;
            s2_reg   <= RST_VAL;
            s3_reg   <= RST_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            s1_reg   <= d_i;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            rise_reg <= s2_reg & ~s3_reg;
            fall_reg <= ~s2_reg & s3_reg;
        end
    end

    assign level_o = s2_reg;
    assign rise_o  = rise_reg;
    assign fall_o  = fall_reg;

endmodule

// File: rtl/cam_capture.sv
// cam_capture: captures RGB565 frames from a parallel camera port into a
// frame buffer as RGB444 pixels, one write per pixel.
//   clk_i, rst_i        - system clock, synchronous active-high reset
//   start_i             - one-cycle capture request (honoured in IDLE only)
//   continuous_i        - 1 = re-arm after every frame, 0 = single frame
//   pclk_i, vsync_i,
//   href_i, data_i      - camera port, asynchronous to clk_i
//   we_o, addr_o,
//   pixel_o             - registered frame-buffer write port
//   frame_done_o        - one-cycle pulse when a captured frame ends
//   busy_o              - high while waiting for a frame or capturing
module cam_capture
    import cam_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic              pclk_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [11:0]       pixel_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    // Bit order {vsync, href, pclk}; vsync idles high (blanking).
    localparam logic [2:0] SYNC_RST = 3'b100;

    logic [2:0] raw_in;
    logic [2:0] lvl_w, rise_w, fall_w;

    assign raw_in = {vsync_i, href_i, pclk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge #(
                .RST_VAL(SYNC_RST[gi])
            ) u_sync (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .d_i    (raw_in[gi]),
                .level_o(lvl_w[gi]),
                .rise_o (rise_w[gi]),
                .fall_o (fall_w[gi])
            );
        end
    endgenerate

    logic pclk_rise, href_lvl, href_fall, vs_rise, vs_fall;
    assign pclk_rise = rise_w[0];
    assign href_lvl  = lvl_w[1];
    assign href_fall = fall_w[1];
    assign vs_rise   = rise_w[2];
    assign vs_fall   = fall_w[2];

    // Synchronizer outputs this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{lvl_w[0], lvl_w[2], fall_w[0], rise_w[1]};

    // Data rides the same two-stage pipeline as pclk so it lines up with
    // the registered pclk edge pulse.
    logic [7:0] d1_reg, d2_reg;

    cam_state_t        state_reg, state_next;
    logic              frame_done_next;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              phase_reg;
    logic [7:0]        hi_reg;
    logic              write_ok;

    assign write_ok = (x_reg < XW'(IMG_W)) && (y_reg < YW'(IMG_H));
    assign busy_o   = (state_reg != ST_IDLE);

    always_comb begin
        state_next      = state_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) state_next = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                // Only a fresh falling edge opens a frame, so a start in
                // the middle of an active frame skips that frame.
                if (vs_fall) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (vs_rise) begin
                    frame_done_next = 1'b1;
                    state_next      = continuous_i ? ST_WAIT_VS : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d1_reg       <= '0;
            d2_reg       <= '0;
            state_reg    <= ST_IDLE;
            frame_done_o <= 1'b0;
            we_o         <= 1'b0;
            addr_o       <= '0;
            pixel_o      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            base_reg     <= '0;
            phase_reg    <= 1'b0;
            hi_reg       <= '0;
        end else begin
            d1_reg       <= data_i;
            d2_reg       <= d1_reg;
            state_reg    <= state_next;
            frame_done_o <= frame_done_next;
            we_o         <= 1'b0;

            if (state_reg == ST_WAIT_VS && vs_fall) begin
                x_reg     <= '0;
                y_reg     <= '0;
                base_reg  <= '0;
                phase_reg <= 1'b0;
            end else if (state_reg == ST_CAPTURE) begin
                // End of a line that produced at least one pixel; empty
                // href pulses do not advance the line.
                if (href_fall && x_reg != '0) begin
                    x_reg <= '0;
                    if (y_reg < YW'(IMG_H)) begin
                        y_reg    <= y_reg + 1'b1;
                        base_reg <= base_reg + ADDR_W'(IMG_W);
                    end
                end

                // Holding phase at 0 outside href drops a dangling odd byte
                // and realigns the next line on its high byte.
                if (!href_lvl) begin
                    phase_reg <= 1'b0;
                end else if (pclk_rise) begin
                    if (!phase_reg) begin
                        hi_reg    <= d2_reg;
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        if (write_ok) begin
                            we_o    <= 1'b1;
                            addr_o  <= base_reg + ADDR_W'(x_reg);
                            pixel_o <= rgb565_to_444(hi_reg, d2_reg);
                        end
                        if (x_reg < XW'(IMG_W)) x_reg <= x_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Testbench for cam_capture with a small 8x4 frame. Expected writes are
// queued as each low byte is driven and checked as the DUT writes them.
module tb_cam_capture;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 17;

    logic              clk_i = 1'b0;
    logic              rst_i, start_i, continuous_i;
    logic              pclk_i, vsync_i, href_i;
    logic [7:0]        data_i;
    logic              we_o, frame_done_o, busy_o;
    logic [ADDR_W-1:0] addr_o;
    logic [11:0]       pixel_o;

    always #5 clk_i = ~clk_i;

    cam_capture #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .continuous_i(continuous_i),
        .pclk_i      (pclk_i),
        .vsync_i     (vsync_i),
        .href_i      (href_i),
        .data_i      (data_i),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .pixel_o     (pixel_o),
        .frame_done_o(frame_done_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       pix;
    } wr_t;

    wr_t sb_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  fd_cnt  = 0;
    int  wr_cnt  = 0;
    bit  m_active;
    int  m_line;
    int  m_x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // RGB565 split into its channels, then each channel cut to 4 bits.
    function automatic logic [11:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        logic [4:0]  r5, b5;
        logic [5:0]  g6;
        w  = {hi, lo};
        r5 = w[15:11];
        g6 = w[10:5];
        b5 = w[4:0];
        return {r5[4:1], g6[5:2], b5[4:1]};
    endfunction

    always @(negedge clk_i) begin
        if (frame_done_o) fd_cnt++;
        if (we_o) begin
            wr_cnt++;
            check("write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("addr", 32'(addr_o), 32'(mon_e.addr));
                check("pixel", 32'(pixel_o), 32'(mon_e.pix));
                $display("[TB] write addr=%0d pixel=0x%03h (exp addr=%0d pixel=0x%03h)",
                         addr_o, pixel_o, mon_e.addr, mon_e.pix);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One pclk period: data set while pclk low, held through the high half.
    task automatic send_byte(input logic [7:0] b, input bit chk_lat);
        logic [3:0] lat;
        pclk_i = 1'b0;
        data_i = b;
        clks(4);
        pclk_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            lat[k] = we_o;
        end
        if (chk_lat) check("we_latency", 32'(lat), 32'h8);
    endtask

    task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
        bit  exp_wr;
        wr_t w;
        exp_wr = m_active && (m_x < IMG_W) && (m_line < IMG_H);
        send_byte(hi, 1'b0);
        if (exp_wr) begin
            w.addr = ADDR_W'(m_line * IMG_W + m_x);
            w.pix  = exp_pix(hi, lo);
            sb_q.push_back(w);
        end
        send_byte(lo, exp_wr);
        if (m_x < IMG_W) m_x++;
    endtask

    task automatic send_line(input int npix, input bit odd, input bit fixed);
        href_i = 1'b1;
        m_x    = 0;
        clks(2);
        for (int i = 0; i < npix; i++) begin
            if (fixed) send_pixel(8'hF8, 8'h1F);
            else       send_pixel(8'($urandom), 8'($urandom));
        end
        if (odd) send_byte(8'($urandom), 1'b0);
        pclk_i = 1'b0;
        href_i = 1'b0;
        clks(8);
        if (npix > 0 && m_line < IMG_H) m_line++;
    endtask

    task automatic vs_set(input logic v);
        vsync_i = v;
        clks(8);
    endtask

    task automatic pulse_start;
        start_i = 1'b1;
        clks(1);
        start_i = 1'b0;
        clks(1);
    endtask

    task automatic frame(input int nlines, input int npix, input bit fixed);
        m_line = 0;
        vs_set(1'b0);
        for (int l = 0; l < nlines; l++) send_line(npix, 1'b0, fixed);
        vs_set(1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    32'(we_o),         32'd0);
        check({tag, "_addr"},  32'(addr_o),       32'd0);
        check({tag, "_pixel"}, 32'(pixel_o),      32'd0);
        check({tag, "_fdone"}, 32'(frame_done_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0, wr0;
        rst_i = 1'b1; start_i = 1'b0; continuous_i = 1'b0;
        pclk_i = 1'b0; vsync_i = 1'b1; href_i = 1'b0; data_i = 8'h00;
        m_active = 1'b0; m_line = 0; m_x = 0;
        clks(3);
        check_outputs_zero("reset");
        rst_i = 1'b0;
        clks(2);

        // Single full frame of 0xF8/0x1F.
        fd0 = fd_cnt; wr0 = wr_cnt;
        pulse_start;
        check("t1_busy_wait", 32'(busy_o), 32'd1);
        m_active = 1'b1;
        frame(4, 8, 1'b1);
        m_active = 1'b0;
        clks(4);
        check("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("t1_writes", 32'(wr_cnt - wr0), 32'd32);
        check("t1_idle_busy", 32'(busy_o), 32'd0);
        frame(2, 8, 1'b0);
        check("t1_no_rearm_writes", 32'(wr_cnt - wr0), 32'd32);
        check("t1_no_rearm_fdone", 32'(fd_cnt - fd0), 32'd1);

        // Over-long line: pixels past IMG_W dropped, next line at addr 8.
        fd0 = fd_cnt; wr0 = wr_cnt;
        pulse_start;
        m_active = 1'b1; m_line = 0;
        vs_set(1'b0);
        send_line(10, 1'b0, 1'b0);
        send_line(2, 1'b0, 1'b0);
        vs_set(1'b1);
        m_active = 1'b0;
        check("t2_writes", 32'(wr_cnt - wr0), 32'd10);
        check("t2_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // Start while vsync already low: current frame skipped.
        fd0 = fd_cnt; wr0 = wr_cnt;
        vs_set(1'b0);
        pulse_start;
        send_line(4, 1'b0, 1'b0);
        vs_set(1'b1);
        check("t3_partial_writes", 32'(wr_cnt - wr0), 32'd0);
        check("t3_partial_fdone", 32'(fd_cnt - fd0), 32'd0);
        m_active = 1'b1;
        frame(1, 3, 1'b0);
        m_active = 1'b0;
        check("t3_writes", 32'(wr_cnt - wr0), 32'd3);
        check("t3_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // Continuous mode over two frames, dropped before the second ends.
        fd0 = fd_cnt; wr0 = wr_cnt;
        continuous_i = 1'b1;
        pulse_start;
        m_active = 1'b1;
        frame(2, 4, 1'b0);
        check("t4_fdone_first", 32'(fd_cnt - fd0), 32'd1);
        check("t4_busy_rearmed", 32'(busy_o), 32'd1);
        continuous_i = 1'b0;
        frame(2, 4, 1'b0);
        m_active = 1'b0;
        clks(2);
        check("t4_fdone_total", 32'(fd_cnt - fd0), 32'd2);
        check("t4_writes", 32'(wr_cnt - wr0), 32'd16);
        check("t4_idle_busy", 32'(busy_o), 32'd0);

        // 3-byte line: one write, dangling byte dropped, next line aligned.
        fd0 = fd_cnt; wr0 = wr_cnt;
        pulse_start;
        m_active = 1'b1; m_line = 0;
        vs_set(1'b0);
        send_line(1, 1'b1, 1'b0);
        send_line(3, 1'b0, 1'b0);
        vs_set(1'b1);
        m_active = 1'b0;
        check("t5_writes", 32'(wr_cnt - wr0), 32'd4);
        check("t5_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // Reset in the middle of a line.
        fd0 = fd_cnt; wr0 = wr_cnt;
        pulse_start;
        m_active = 1'b1; m_line = 0;
        vs_set(1'b0);
        href_i = 1'b1; m_x = 0;
        clks(2);
        for (int i = 0; i < 3; i++) send_pixel(8'($urandom), 8'($urandom));
        rst_i = 1'b1;
        clks(1);
        check_outputs_zero("t6_rst");
        clks(1);
        rst_i = 1'b0;
        m_active = 1'b0;
        for (int i = 0; i < 2; i++) send_pixel(8'($urandom), 8'($urandom));
        pclk_i = 1'b0; href_i = 1'b0;
        clks(8);
        vs_set(1'b1);
        vs_set(1'b0);
        send_line(2, 1'b0, 1'b0);
        vs_set(1'b1);
        check("t6_no_writes", 32'(wr_cnt - wr0), 32'd3);
        check("t6_no_fdone", 32'(fd_cnt - fd0), 32'd0);
        check("t6_idle_busy", 32'(busy_o), 32'd0);
        pulse_start;
        m_active = 1'b1;
        frame(1, 2, 1'b0);
        m_active = 1'b0;
        check("t6_restart_writes", 32'(wr_cnt - wr0), 32'd5);
        check("t6_restart_fdone", 32'(fd_cnt - fd0), 32'd1);

        clks(4);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
